// File: rtl/sched_queue_n_if.sv
// Request/grant bundle between the thread sequencer (master) and the
// schedule-deferral queue (slave).
interface sched_queue_n_if #(
    parameter int THREADS = 4,
    parameter int DEPTH   = 8
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IDW = $clog2(THREADS);

    logic [THREADS-1:0]    SCHED_REQ;
    logic                  LOCKED;
    logic                  RPT_not_z;
    logic [THREADS-1:0]    FLUSH;
    logic                  OVFL_CLR;
    logic [THREADS-1:0]    SCHED_Q;
    logic                  GRANT_VLD;
    logic [IDW-1:0]        GRANT_ID;
    logic [THREADS*CW-1:0] PEND_CNT;
    logic [THREADS-1:0]    OVFL;

    modport master (
        output SCHED_REQ, LOCKED, RPT_not_z, FLUSH, OVFL_CLR,
        input  SCHED_Q, GRANT_VLD, GRANT_ID, PEND_CNT, OVFL
    );

    modport slave (
        input  SCHED_REQ, LOCKED, RPT_not_z, FLUSH, OVFL_CLR,
        output SCHED_Q, GRANT_VLD, GRANT_ID, PEND_CNT, OVFL
    );
endinterface

// File: rtl/sched_queue_n.sv
// N-thread fixed-priority schedule arbiter; requests that lose arbitration
// are deferred in per-thread saturating counters and issued later.
module sched_queue_n #(
    parameter  int THREADS = 4,
    parameter  int DEPTH   = 8,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int IDW     = $clog2(THREADS)
) (
    input logic            CLK,
    input logic            RESET,
    sched_queue_n_if.slave bus
);
    logic                  hold;
    logic [THREADS-1:0]    elig;
    logic                  win_vld;
    logic [IDW-1:0]        win_id;
    logic [THREADS-1:0]    win_oh;
    logic [THREADS-1:0]    ovfl_set;
    logic [CW-1:0]         cnt_q [THREADS];
    logic [CW-1:0]         cnt_d [THREADS];
    logic [THREADS-1:0]    sched_q;
    logic                  grant_vld_q;
    logic [IDW-1:0]        grant_id_q;
    logic [THREADS-1:0]    ovfl_q;

    assign hold = bus.LOCKED | bus.RPT_not_z;

    always_comb begin
        elig = '0;
        for (int k = 0; k < THREADS; k++)
            elig[k] = bus.SCHED_REQ[k] | ((cnt_q[k] != '0) & ~bus.FLUSH[k]);
    end

    // Scan from the top so the lowest eligible index is the last one written.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = THREADS - 1; k >= 0; k--) begin
            if (elig[k]) begin
                win_vld = 1'b1;
                win_id  = IDW'(k);
            end
        end
    end

    assign win_oh = win_vld ? (THREADS'(1) << win_id) : '0;

    always_comb begin
        ovfl_set = '0;
        for (int k = 0; k < THREADS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (hold) begin
                if (bus.FLUSH[k])
                    cnt_d[k] = '0;
            end else if (bus.FLUSH[k]) begin
                // A live losing request outlives the flush of older entries.
                cnt_d[k] = (bus.SCHED_REQ[k] && !win_oh[k]) ? CW'(1) : '0;
            end else if (win_oh[k]) begin
                if (!bus.SCHED_REQ[k])
                    cnt_d[k] = cnt_q[k] - CW'(1);
            end else if (bus.SCHED_REQ[k]) begin
                if (cnt_q[k] != CW'(DEPTH))
                    cnt_d[k] = cnt_q[k] + CW'(1);
                else
                    ovfl_set[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sched_q     <= '0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
            ovfl_q      <= '0;
            for (int k = 0; k < THREADS; k++)
                cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < THREADS; k++)
                cnt_q[k] <= cnt_d[k];
            ovfl_q <= (ovfl_q & ~{THREADS{bus.OVFL_CLR}}) | ovfl_set;
            if (!hold) begin
                sched_q     <= win_oh;
                grant_vld_q <= win_vld;
                grant_id_q  <= win_id;
            end
        end
    end

    assign bus.SCHED_Q   = sched_q;
    assign bus.GRANT_VLD = grant_vld_q;
    assign bus.GRANT_ID  = grant_id_q;
    assign bus.OVFL      = ovfl_q;

    for (genvar g = 0; g < THREADS; g++) begin : g_pend
        assign bus.PEND_CNT[g*CW +: CW] = cnt_q[g];
    end
endmodule

// File: tb/tb_sched_queue_n.sv
// Bench for sched_queue_n: directed scenarios on a 4x8 instance plus random
// regression of 4x8 and 6x3 instances against a behavioural model.
module tb_sched_queue_n;
    logic CLK = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;

    // model state per instance: 0 = 4 threads/depth 8, 1 = 6 threads/depth 3
    int m_cnt  [2][8];
    int m_ovfl [2];
    int m_gid  [2];
    int m_gvld [2];

    sched_queue_n_if #(.THREADS(4), .DEPTH(8)) if_a ();
    sched_queue_n_if #(.THREADS(6), .DEPTH(3)) if_b ();

    sched_queue_n #(.THREADS(4), .DEPTH(8)) u_a (.CLK(CLK), .RESET(rst_a), .bus(if_a.slave));
    sched_queue_n #(.THREADS(6), .DEPTH(3)) u_b (.CLK(CLK), .RESET(rst_b), .bus(if_b.slave));

    always #5 CLK = ~CLK;

    task automatic model_step(input int d);
        int n, dep, req, fl, w, set_m;
        bit hold, clr, rst;
        if (d == 0) begin
            n = 4; dep = 8; req = int'(if_a.SCHED_REQ); fl = int'(if_a.FLUSH);
            hold = if_a.LOCKED | if_a.RPT_not_z; clr = if_a.OVFL_CLR; rst = rst_a;
        end else begin
            n = 6; dep = 3; req = int'(if_b.SCHED_REQ); fl = int'(if_b.FLUSH);
            hold = if_b.LOCKED | if_b.RPT_not_z; clr = if_b.OVFL_CLR; rst = rst_b;
        end
        if (rst) begin
            for (int k = 0; k < 8; k++) m_cnt[d][k] = 0;
            m_ovfl[d] = 0; m_gid[d] = 0; m_gvld[d] = 0;
            return;
        end
        if (clr) m_ovfl[d] = 0;
        if (hold) begin
            for (int k = 0; k < n; k++) if (fl[k]) m_cnt[d][k] = 0;
            return;
        end
        w = -1;
        for (int k = 0; k < n; k++)
            if (w < 0 && (req[k] || (m_cnt[d][k] > 0 && !fl[k]))) w = k;
        set_m = 0;
        for (int k = 0; k < n; k++) begin
            if (fl[k])                m_cnt[d][k] = (req[k] && k != w) ? 1 : 0;
            else if (k == w)          m_cnt[d][k] -= req[k] ? 0 : 1;
            else if (req[k]) begin
                if (m_cnt[d][k] < dep) m_cnt[d][k] += 1;
                else                   set_m |= (1 << k);
            end
        end
        m_ovfl[d] |= set_m;
        m_gvld[d] = (w >= 0) ? 1 : 0;
        m_gid[d]  = (w >= 0) ? w : 0;
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_a(input logic [3:0] req, input logic [3:0] fl, input logic lk,
                         input logic rp, input logic clr, input logic rst);
        if_a.SCHED_REQ = req; if_a.FLUSH = fl; if_a.LOCKED = lk;
        if_a.RPT_not_z = rp; if_a.OVFL_CLR = clr; rst_a = rst;
    endtask

    function automatic int pa(input int k);
        return int'(if_a.PEND_CNT[k*4 +: 4]);
    endfunction

    task automatic test_reset();
        set_a(4'b0000, 4'b0000, 0, 0, 0, 1); rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        checks++; if (if_a.SCHED_Q !== 4'b0000 || if_a.GRANT_VLD !== 1'b0 || if_a.OVFL !== 4'b0000 || if_a.PEND_CNT !== 16'h0)
            begin errors++; $display("FAIL reset_init: q=%b vld=%b ovfl=%b pend=%h exp all 0", if_a.SCHED_Q, if_a.GRANT_VLD, if_a.OVFL, if_a.PEND_CNT); end
        set_a(4'b0011, 4'b0000, 0, 0, 0, 0);
        repeat (9) tick();
        set_a(4'b0101, 4'b0000, 0, 0, 0, 0);
        repeat (3) tick();
        checks++; if (pa(2) != 3 || pa(1) != 8 || if_a.OVFL !== 4'b0010)
            begin errors++; $display("FAIL reset_setup: cnt2=%0d cnt1=%0d ovfl=%b exp 3 8 0010", pa(2), pa(1), if_a.OVFL); end
        set_a(4'b0101, 4'b0000, 0, 0, 0, 1);
        tick();
        checks++; if (if_a.SCHED_Q !== 4'b0000 || if_a.GRANT_VLD !== 1'b0 || if_a.GRANT_ID !== 2'd0 || if_a.OVFL !== 4'b0000 || if_a.PEND_CNT !== 16'h0)
            begin errors++; $display("FAIL reset_mid: q=%b vld=%b id=%0d ovfl=%b pend=%h exp all 0", if_a.SCHED_Q, if_a.GRANT_VLD, if_a.GRANT_ID, if_a.OVFL, if_a.PEND_CNT); end
        set_a(4'b0000, 4'b0000, 0, 0, 0, 0);
    endtask

    task automatic test_deferral();
        logic [3:0] exp_q [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000};
        int exp_id [4] = '{0, 1, 3, 0};
        int exp_c1 [4] = '{1, 0, 0, 0};
        int exp_c3 [4] = '{1, 1, 0, 0};
        set_a(4'b1011, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            set_a(4'b0000, 4'b0000, 0, 0, 0, 0);
            checks++; if (if_a.SCHED_Q !== exp_q[i] || int'(if_a.GRANT_ID) != exp_id[i] || if_a.GRANT_VLD !== (exp_q[i] != 0))
                begin errors++; $display("FAIL defer_grant[%0d]: q=%b id=%0d vld=%b exp q=%b id=%0d", i, if_a.SCHED_Q, if_a.GRANT_ID, if_a.GRANT_VLD, exp_q[i], exp_id[i]); end
            checks++; if (pa(1) != exp_c1[i] || pa(3) != exp_c3[i])
                begin errors++; $display("FAIL defer_cnt[%0d]: cnt1=%0d cnt3=%0d exp %0d %0d", i, pa(1), pa(3), exp_c1[i], exp_c3[i]); end
        end
    endtask

    task automatic test_saturation();
        set_a(4'b0101, 4'b0000, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if (pa(2) != ((i < 8) ? i : 8) || if_a.OVFL[2] !== (i >= 9) || if_a.SCHED_Q !== 4'b0001)
                begin errors++; $display("FAIL sat_fill[%0d]: cnt2=%0d ovfl2=%b q=%b exp cnt2=%0d", i, pa(2), if_a.OVFL[2], if_a.SCHED_Q, (i < 8) ? i : 8); end
        end
        set_a(4'b0000, 4'b0000, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if (pa(2) != 8 - i || if_a.SCHED_Q !== 4'b0100 || if_a.GRANT_ID !== 2'd2 || if_a.OVFL[2] !== 1'b1)
                begin errors++; $display("FAIL sat_drain[%0d]: cnt2=%0d q=%b id=%0d ovfl2=%b exp cnt2=%0d q=0100", i, pa(2), if_a.SCHED_Q, if_a.GRANT_ID, if_a.OVFL[2], 8 - i); end
        end
        tick();
        checks++; if (if_a.SCHED_Q !== 4'b0000 || if_a.GRANT_VLD !== 1'b0)
            begin errors++; $display("FAIL sat_idle: q=%b vld=%b exp 0", if_a.SCHED_Q, if_a.GRANT_VLD); end
        set_a(4'b0000, 4'b0000, 0, 0, 1, 0);
        tick();
        set_a(4'b0000, 4'b0000, 0, 0, 0, 0);
        checks++; if (if_a.OVFL !== 4'b0000)
            begin errors++; $display("FAIL sat_clr: ovfl=%b exp 0000", if_a.OVFL); end
    endtask

    task automatic test_hold();
        set_a(4'b0000, 4'b0000, 0, 0, 0, 1); tick();
        set_a(4'b0011, 4'b0000, 0, 0, 0, 0); repeat (2) tick();
        for (int r = 0; r < 2; r++) begin
            set_a(4'b0101, 4'b0000, (r == 0), (r == 1), 0, 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++; if (if_a.SCHED_Q !== 4'b0001 || if_a.GRANT_ID !== 2'd0 || pa(1) != 2 || pa(2) != 0)
                    begin errors++; $display("FAIL hold[%0d][%0d]: q=%b id=%0d cnt1=%0d cnt2=%0d exp 0001 0 2 0", r, i, if_a.SCHED_Q, if_a.GRANT_ID, pa(1), pa(2)); end
            end
            set_a(4'b0000, 4'b0000, 0, 0, 0, 0); tick();
            checks++; if (if_a.SCHED_Q !== 4'b0010 || pa(1) != 1)
                begin errors++; $display("FAIL hold_release[%0d]: q=%b cnt1=%0d exp 0010 1", r, if_a.SCHED_Q, pa(1)); end
            set_a(4'b0011, 4'b0000, 0, 0, 0, 0); tick();
        end
        set_a(4'b0000, 4'b0000, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        set_a(4'b0000, 4'b0000, 0, 0, 0, 1); tick();
        set_a(4'b1001, 4'b0000, 0, 0, 0, 0); repeat (5) tick();
        checks++; if (pa(3) != 5)
            begin errors++; $display("FAIL flush_setup: cnt3=%0d exp 5", pa(3)); end
        set_a(4'b1001, 4'b1000, 0, 0, 0, 0); tick();
        checks++; if (pa(3) != 1 || if_a.SCHED_Q !== 4'b0001)
            begin errors++; $display("FAIL flush_live: cnt3=%0d q=%b exp 1 0001", pa(3), if_a.SCHED_Q); end
        set_a(4'b0000, 4'b1000, 0, 0, 0, 0); tick();
        checks++; if (pa(3) != 0 || if_a.SCHED_Q !== 4'b0000 || if_a.GRANT_VLD !== 1'b0)
            begin errors++; $display("FAIL flush_only: cnt3=%0d q=%b vld=%b exp 0 0000 0", pa(3), if_a.SCHED_Q, if_a.GRANT_VLD); end
        set_a(4'b1001, 4'b0000, 0, 0, 0, 0); repeat (2) tick();
        set_a(4'b0000, 4'b1000, 1, 0, 0, 0); tick();
        checks++; if (pa(3) != 0 || if_a.SCHED_Q !== 4'b0001)
            begin errors++; $display("FAIL flush_hold: cnt3=%0d q=%b exp 0 0001", pa(3), if_a.SCHED_Q); end
        set_a(4'b0000, 4'b0000, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            set_a(4'($urandom), 4'($urandom & $urandom & $urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
            if_b.SCHED_REQ = 6'($urandom);
            if_b.FLUSH     = 6'($urandom & $urandom & $urandom);
            if_b.LOCKED    = ($urandom_range(0, 9) == 0);
            if_b.RPT_not_z = ($urandom_range(0, 9) == 0);
            if_b.OVFL_CLR  = ($urandom_range(0, 19) == 0);
            rst_b          = ($urandom_range(0, 299) == 0);
            tick();
            checks++; if (int'(if_a.SCHED_Q) != (m_gvld[0] ? (1 << m_gid[0]) : 0) || int'(if_a.GRANT_ID) != m_gid[0] || int'(if_a.GRANT_VLD) != m_gvld[0])
                begin errors++; $display("FAIL rand_a_grant[%0d]: q=%b id=%0d vld=%b exp vld=%0d id=%0d", i, if_a.SCHED_Q, if_a.GRANT_ID, if_a.GRANT_VLD, m_gvld[0], m_gid[0]); end
            checks++; if (int'(if_b.SCHED_Q) != (m_gvld[1] ? (1 << m_gid[1]) : 0) || int'(if_b.GRANT_ID) != m_gid[1] || int'(if_b.GRANT_VLD) != m_gvld[1])
                begin errors++; $display("FAIL rand_b_grant[%0d]: q=%b id=%0d vld=%b exp vld=%0d id=%0d", i, if_b.SCHED_Q, if_b.GRANT_ID, if_b.GRANT_VLD, m_gvld[1], m_gid[1]); end
            checks++; if (int'(if_a.OVFL) != m_ovfl[0] || int'(if_b.OVFL) != m_ovfl[1])
                begin errors++; $display("FAIL rand_ovfl[%0d]: a=%b b=%b exp a=%0h b=%0h", i, if_a.OVFL, if_b.OVFL, m_ovfl[0], m_ovfl[1]); end
            for (int k = 0; k < 6; k++) begin
                if (k < 4) begin
                    checks++; if (pa(k) != m_cnt[0][k])
                        begin errors++; $display("FAIL rand_a_cnt[%0d][%0d]: got %0d exp %0d", i, k, pa(k), m_cnt[0][k]); end
                end
                checks++; if (int'(if_b.PEND_CNT[k*2 +: 2]) != m_cnt[1][k])
                    begin errors++; $display("FAIL rand_b_cnt[%0d][%0d]: got %0d exp %0d", i, k, if_b.PEND_CNT[k*2 +: 2], m_cnt[1][k]); end
            end
        end
    endtask

    initial begin
        set_a(4'b0000, 4'b0000, 0, 0, 0, 1);
        rst_b = 1'b1;
        if_b.SCHED_REQ = '0; if_b.FLUSH = '0; if_b.LOCKED = 1'b0;
        if_b.RPT_not_z = 1'b0; if_b.OVFL_CLR = 1'b0;
        test_reset();
        test_deferral();
        test_saturation();
        test_hold();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sched_queue_n.md
Name: sched_queue_n

Overview:
- Parametrised successor to the four-thread schedule-deferral stack.
- Arbitrates per-thread schedule requests by fixed priority; thread 0 is highest.
- A request that loses arbitration is counted in a per-thread pending counter and issued later, when no higher-priority thread is eligible.
- Adds N-thread width, binary counters of configurable depth, one-hot and encoded grant outputs, per-thread flush, sticky overflow flags and pending-count visibility. Sits between the thread sequencer and the issue stage.

Parameters:
- THREADS, 4, number of threads (min 2); index 0 is highest priority.
- DEPTH, 8, maximum deferred requests per thread (min 1).
- CW, $clog2(DEPTH+1), pending-counter width (derived, do not override).
- IDW, $clog2(THREADS), encoded grant width (derived).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- SCHED_REQ  in  THREADS  per-thread schedule request, one-cycle pulse per request.
- LOCKED  in  1  freeze scheduling state.
- RPT_not_z  in  1  repeat counter non-zero; freezes scheduling state.
- FLUSH  in  THREADS  per-thread discard of all pending requests.
- OVFL_CLR  in  1  clear all sticky overflow flags.
- SCHED_Q  out  THREADS  registered one-hot grant.
- GRANT_VLD  out  1  registered; equals |SCHED_Q.
- GRANT_ID  out  IDW  registered index of the granted thread; 0 when GRANT_VLD=0.
- PEND_CNT  out  THREADS*CW  pending counts; thread k occupies bits [k*CW +: CW].
- OVFL  out  THREADS  sticky per-thread overflow flag.

Behaviour:
- Reset (synchronous, dominates all inputs): all counters 0; SCHED_Q, GRANT_VLD, GRANT_ID and OVFL all 0.
- Hold: hold = LOCKED | RPT_not_z.
  - While hold=1: SCHED_Q, GRANT_VLD, GRANT_ID, counters and OVFL all keep their values; SCHED_REQ is ignored and those requests are lost.
  - FLUSH and OVFL_CLR still act while hold=1.
- Eligibility per cycle (hold=0): elig[k] = SCHED_REQ[k] | (cnt[k]!=0 & ~FLUSH[k]).
- Winner w = lowest index k with elig[k]=1. Thread 0 is therefore never deferred.
- Grant is registered, one-cycle latency: next cycle SCHED_Q = one-hot(w), GRANT_ID = w, GRANT_VLD = 1.
  - If no thread is eligible, all three are 0 next cycle.
  - At most one SCHED_Q bit is ever set.
- Counter update for thread k (hold=0), evaluated in priority order; first match wins:
  1. FLUSH[k] & ~(SCHED_REQ[k] & k!=w): cnt <= 0.
  2. FLUSH[k] & SCHED_REQ[k] & k!=w: cnt <= 1. The live request survives the flush.
  3. k==w & SCHED_REQ[k]: direct issue; cnt unchanged.
  4. k==w & ~SCHED_REQ[k]: pop; cnt <= cnt-1.
  5. k!=w & SCHED_REQ[k] & cnt<DEPTH: push; cnt <= cnt+1.
  6. k!=w & SCHED_REQ[k] & cnt==DEPTH: request dropped; cnt stays DEPTH; OVFL[k] <= 1.
  7. Otherwise: cnt unchanged.
- FLUSH while hold=1: cnt[k] <= 0; no push or pop.
- Counters never wrap: push is blocked at DEPTH; pop only occurs when cnt!=0 (implied by eligibility).
- OVFL: set by rule 6; cleared by OVFL_CLR. A set and a clear for the same thread in the same cycle resolves to set.
- A pending request issues only in a cycle with no higher-priority eligibility.
  - Starvation of low threads under continuous high-priority requests is accepted and must not be altered.
- PEND_CNT is the registered counter state (no combinational path from inputs).

Test Plan:
- Reset: assert RESET mid-traffic with cnt[2]=3 and OVFL[1]=1 -> next cycle all counters 0, SCHED_Q=0, OVFL=0, GRANT_VLD=0.
- Conflict/deferral (THREADS=4): SCHED_REQ=4'b1011 for one cycle, then 0 -> cycle+1 SCHED_Q=0001, cnt[1]=1, cnt[3]=1. Then SCHED_Q=0010 (cnt[1]=0), then 1000 (cnt[3]=0), then 0; GRANT_ID sequence 0,1,3,0.
- Saturation (DEPTH=8): hold REQ[0] and REQ[2] high for 10 cycles -> cnt[2] reaches 8 and stays 8, OVFL[2]=1 from the 9th cycle. Drop REQ[0] -> thread 2 is granted 8 consecutive cycles, cnt[2] counts 8->0. OVFL_CLR -> OVFL[2]=0.
- Hold: with cnt[1]=2, pulse LOCKED for 3 cycles with SCHED_REQ=4'b0101 -> SCHED_Q and cnt frozen, requests lost. Repeat with RPT_not_z -> same result.
- Flush: cnt[3]=5 with FLUSH[3] & REQ[3] & REQ[0] -> cnt[3]=1. FLUSH[3] alone -> cnt[3]=0, no grant to thread 3.
- Parametrisation: THREADS=6, DEPTH=3 random request regression vs. reference model -> one-hot grant, counters within 0..3, GRANT_ID matches SCHED_Q every cycle.
